// File: rtl/rgmii_pkg.sv
// Shared types, constants and the reflected CRC-32 byte step used by the RGMII transmit framer.
package rgmii_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SFD,
    ST_PAYLOAD,
    ST_PAD,
    ST_FCS,
    ST_IFG,
    ST_DISCARD
  } tx_state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;

  // Control pairs are {TX_EN^TX_ER, TX_EN}.
  localparam logic [1:0]  CTRL_IDLE     = 2'b00;
  localparam logic [1:0]  CTRL_DATA     = 2'b11;
  localparam logic [1:0]  CTRL_ERROR    = 2'b01;

  function automatic logic [31:0] crc32_byte_update(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/rgmii_transmit_framer_crc32_generator.sv
// Running reflected CRC-32 register; the caller inverts the result to form the FCS.
module crc32_generator (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        enable,
  input  logic [7:0]  data,
  output logic [31:0] crc
);
  import rgmii_pkg::*;

  logic [31:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clear) begin
      crc_d = CRC_INIT;
    end else if (enable) begin
      crc_d = crc32_byte_update(crc_q, data);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/rgmii_transmit_framer.sv
// Gigabit RGMII transmit framer: preamble/SFD insertion, padding, CRC-32 FCS and inter-frame gap,
// with one registered byte and control pair per clock for the DDR output stage.
module rgmii_transmit_framer #(
  parameter int unsigned PREAMBLE_BYTES  = 7,
  parameter int unsigned MIN_FRAME_BYTES = 60,
  parameter int unsigned IFG_CYCLES      = 12
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] tx_ddr_data,
  output logic [1:0] tx_ddr_control,
  output logic       busy,
  output logic       underrun_error
);
  import rgmii_pkg::*;

  localparam logic [15:0] MIN_LEN  = 16'(MIN_FRAME_BYTES);
  localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_BYTES - 1);
  localparam logic [7:0]  IFG_LAST = 8'(IFG_CYCLES - 1);

  tx_state_e   state_q, state_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]  phase_q, phase_d;
  logic [7:0]  data_q, data_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic        underrun_q, underrun_d;
  logic        ready_q, busy_q;

  logic        crc_clear, crc_enable;
  logic [7:0]  crc_data;
  logic [31:0] crc_value, fcs;
  logic [7:0]  fcs_byte;
  logic [15:0] cnt_inc;

  crc32_generator u_crc (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (crc_clear),
    .enable  (crc_enable),
    .data    (crc_data),
    .crc     (crc_value)
  );

  assign fcs      = ~crc_value;
  assign fcs_byte = fcs[{phase_q[1:0], 3'b000} +: 8];
  assign cnt_inc  = (byte_cnt_q == 16'hFFFF) ? byte_cnt_q : byte_cnt_q + 16'd1;

  // Each state decides the byte registered onto the wire at the next edge.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    phase_d    = phase_q;
    data_d     = 8'h00;
    ctrl_d     = CTRL_IDLE;
    underrun_d = 1'b0;
    crc_clear  = 1'b0;
    crc_enable = 1'b0;
    crc_data   = s_data;
    case (state_q)
      ST_IDLE: begin
        crc_clear  = 1'b1;
        byte_cnt_d = 16'd0;
        phase_d    = 8'd0;
        if (s_valid) state_d = ST_PREAMBLE;
      end
      ST_PREAMBLE: begin
        data_d = PREAMBLE_BYTE;
        ctrl_d = CTRL_DATA;
        if (phase_q == PRE_LAST) begin
          phase_d = 8'd0;
          state_d = ST_SFD;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      ST_SFD: begin
        data_d     = SFD_BYTE;
        ctrl_d     = CTRL_DATA;
        crc_clear  = 1'b1;
        byte_cnt_d = 16'd0;
        state_d    = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        if (s_valid) begin
          data_d     = s_data;
          ctrl_d     = CTRL_DATA;
          crc_enable = 1'b1;
          byte_cnt_d = cnt_inc;
          if (s_last) state_d = (cnt_inc < MIN_LEN) ? ST_PAD : ST_FCS;
        end else begin
          ctrl_d     = CTRL_ERROR;
          underrun_d = 1'b1;
          state_d    = ST_DISCARD;
        end
      end
      ST_DISCARD: begin
        if (s_valid && s_last) begin
          phase_d = 8'd0;
          state_d = ST_IFG;
        end
      end
      ST_PAD: begin
        ctrl_d     = CTRL_DATA;
        crc_enable = 1'b1;
        crc_data   = 8'h00;
        byte_cnt_d = cnt_inc;
        if (cnt_inc >= MIN_LEN) state_d = ST_FCS;
      end
      ST_FCS: begin
        data_d = fcs_byte;
        ctrl_d = CTRL_DATA;
        if (phase_q == 8'd3) begin
          phase_d = 8'd0;
          state_d = ST_IFG;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      ST_IFG: begin
        // A waiting frame skips IDLE so the gap is exactly IFG_CYCLES long.
        if (phase_q == IFG_LAST) begin
          phase_d = 8'd0;
          state_d = s_valid ? ST_PREAMBLE : ST_IDLE;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= 16'd0;
      phase_q    <= 8'd0;
      data_q     <= 8'h00;
      ctrl_q     <= CTRL_IDLE;
      underrun_q <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      phase_q    <= phase_d;
      data_q     <= data_d;
      ctrl_q     <= ctrl_d;
      underrun_q <= underrun_d;
      ready_q    <= (state_d == ST_PAYLOAD) || (state_d == ST_DISCARD);
      busy_q     <= (state_d != ST_IDLE);
    end
  end

  assign s_ready        = ready_q;
  assign tx_ddr_data    = data_q;
  assign tx_ddr_control = ctrl_q;
  assign busy           = busy_q;
  assign underrun_error = underrun_q;

endmodule

// File: tb/tb_rgmii_transmit_framer.sv
// Self-checking bench for rgmii_transmit_framer: table vectors, corner sequences and random frames
// compared against a frame-level model (preamble, pad, bit-serial CRC).
module tb_rgmii_transmit_framer;

  localparam int PRE    = 7;
  localparam int MINLEN = 60;
  localparam int IFG    = 12;

  logic       clock = 1'b0;
  logic       resetN;
  logic [7:0] sData;
  logic       sValid, sLast;

  logic [7:0] txData, npData;
  logic [1:0] txCtrl, npCtrl;
  logic       sReady, busy, underrunError;
  logic       npReady, npBusy, npUnderrun;

  int total = 0;
  int bad   = 0;

  logic [7:0]  txBytes[$];
  bit          txLast[$];
  logic [7:0]  expBytes[$];
  int          expLen[$];
  logic [7:0]  gotData[$];
  logic [1:0]  gotCtrl[$];
  logic [31:0] lastFcs;
  int          lastRunLen;

  typedef struct {
    string       name;
    int          len;
    logic [7:0]  startVal;
    bit          noPad;
    int          expLen;
    bit          fcsKnown;
    logic [31:0] expFcs;
  } vec_t;

  vec_t vecs[6];

  always #4 clock = ~clock;

  rgmii_transmit_framer dut (
    .clock          (clock),
    .reset_n        (resetN),
    .s_data         (sData),
    .s_valid        (sValid),
    .s_last         (sLast),
    .s_ready        (sReady),
    .tx_ddr_data    (txData),
    .tx_ddr_control (txCtrl),
    .busy           (busy),
    .underrun_error (underrunError)
  );

  rgmii_transmit_framer #(.MIN_FRAME_BYTES(0)) dutNoPad (
    .clock          (clock),
    .reset_n        (resetN),
    .s_data         (sData),
    .s_valid        (sValid),
    .s_last         (sLast),
    .s_ready        (npReady),
    .tx_ddr_data    (npData),
    .tx_ddr_control (npCtrl),
    .busy           (npBusy),
    .underrun_error (npUnderrun)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, required);
    end
  endtask

  task automatic resetDut();
    resetN = 1'b0;
    sValid = 1'b0;
    sLast  = 1'b0;
    sData  = 8'h00;
    repeat (3) @(negedge clock);
    resetN = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic clearFrames();
    txBytes.delete();
    txLast.delete();
    expBytes.delete();
    expLen.delete();
  endtask

  // Expected wire image of one frame, built from the framing rules rather than any state machine.
  task automatic modelFrame(input int startIdx, input int len, input int minBytes);
    logic [7:0]  body[$];
    logic [31:0] crc;
    bit          fb;
    for (int i = 0; i < PRE; i++) expBytes.push_back(8'h55);
    expBytes.push_back(8'hD5);
    for (int i = 0; i < len; i++) body.push_back(txBytes[startIdx + i]);
    while (body.size() < minBytes) body.push_back(8'h00);
    crc = 32'hFFFFFFFF;
    foreach (body[i]) begin
      for (int b = 0; b < 8; b++) begin
        fb  = crc[0] ^ body[i][b];
        crc = crc >> 1;
        if (fb) crc = crc ^ 32'hEDB88320;
      end
    end
    crc = ~crc;
    foreach (body[i]) expBytes.push_back(body[i]);
    for (int k = 0; k < 4; k++) expBytes.push_back(crc[8*k +: 8]);
    expLen.push_back(PRE + 1 + body.size() + 4);
  endtask

  task automatic addFrame(input int len, input logic [7:0] startVal, input bit randomData, input int minBytes);
    int start;
    start = txBytes.size();
    for (int i = 0; i < len; i++) begin
      txBytes.push_back(randomData ? 8'($urandom_range(0, 255)) : startVal + 8'(i));
      txLast.push_back(i == len - 1);
    end
    modelFrame(start, len, minBytes);
  endtask

  // Streams txBytes with s_valid held high and records the wire from the first active cycle.
  task automatic applyStimulus(input int nFrames, input bit useNoPad);
    int         idx, cyc, runsDone, bound;
    bit         started, prevNz, acc;
    logic [7:0] d;
    logic [1:0] c;
    logic       r;
    gotData.delete();
    gotCtrl.delete();
    idx = 0; cyc = 0; runsDone = 0; started = 0; prevNz = 0;
    bound = 2 * txBytes.size() + 200 * nFrames;
    @(posedge clock);
    #1;
    sValid = 1'b1;
    sData  = txBytes[0];
    sLast  = txLast[0];
    while (runsDone < nFrames && cyc < bound) begin
      @(negedge clock);
      cyc++;
      d = useNoPad ? npData  : txData;
      c = useNoPad ? npCtrl  : txCtrl;
      r = useNoPad ? npReady : sReady;
      if (c != 2'b00) started = 1;
      if (started) begin
        gotData.push_back(d);
        gotCtrl.push_back(c);
      end
      if (prevNz && c == 2'b00) runsDone++;
      prevNz = (c != 2'b00);
      acc = sValid && r;
      @(posedge clock);
      #1;
      if (acc) begin
        idx++;
        if (idx < txBytes.size()) begin
          sData = txBytes[idx];
          sLast = txLast[idx];
        end else begin
          sValid = 1'b0;
          sLast  = 1'b0;
          sData  = 8'h00;
        end
      end
    end
    sValid = 1'b0;
    sLast  = 1'b0;
    checkOutput("frames completed in time", runsDone, nFrames);
  endtask

  task automatic checkFrames(input string tag, input int nFrames, input bit checkGap);
    int pos, ep, gap, len, byteErr, ctrlErr;
    pos = 0;
    ep  = 0;
    for (int f = 0; f < nFrames; f++) begin
      gap = 0;
      while (pos < gotCtrl.size() && gotCtrl[pos] == 2'b00) begin
        gap++;
        pos++;
      end
      if (checkGap && f > 0) checkOutput($sformatf("%s gap before frame %0d", tag, f), gap, IFG);
      len = 0; byteErr = 0; ctrlErr = 0;
      while (pos < gotCtrl.size() && gotCtrl[pos] != 2'b00) begin
        if (gotCtrl[pos] != 2'b11) ctrlErr++;
        if (len < expLen[f] && gotData[pos] !== expBytes[ep + len]) begin
          if (byteErr == 0)
            $display("[TB]   %s first byte difference at %0d: got %h want %h", tag, len, gotData[pos], expBytes[ep + len]);
          byteErr++;
        end
        len++;
        pos++;
      end
      lastRunLen = len;
      if (len >= 4) lastFcs = {gotData[pos-1], gotData[pos-2], gotData[pos-3], gotData[pos-4]};
      checkOutput($sformatf("%s frame %0d length", tag, f), len, expLen[f]);
      checkOutput($sformatf("%s frame %0d wrong bytes", tag, f), byteErr, 0);
      checkOutput($sformatf("%s frame %0d non-data control", tag, f), ctrlErr, 0);
      ep += expLen[f];
    end
  endtask

  task automatic runUnderrun();
    int         accepted, stage, pulses, errCycles, busyAfter, wrong;
    logic [7:0] errData;
    logic [7:0] expU[$];
    bit         acc;
    resetDut();
    gotData.delete();
    for (int i = 0; i < PRE; i++) expU.push_back(8'h55);
    expU.push_back(8'hD5);
    for (int i = 0; i < 10; i++) expU.push_back(8'h10 + 8'(i));
    accepted = 0; stage = 0; pulses = 0; errCycles = 0; busyAfter = 0; errData = 8'h00;
    @(posedge clock);
    #1;
    sValid = 1'b1;
    sData  = 8'h10;
    sLast  = 1'b0;
    for (int cyc = 0; cyc < 500 && stage != 4; cyc++) begin
      @(negedge clock);
      if (txCtrl == 2'b11) gotData.push_back(txData);
      if (txCtrl == 2'b01) begin
        errCycles++;
        errData = errData | txData;
      end
      if (underrunError) pulses++;
      if (stage == 3) begin
        if (busy) busyAfter++;
        else stage = 4;
      end
      acc = sValid && sReady;
      if (stage != 4) begin
        @(posedge clock);
        #1;
        if (stage == 1) begin
          sValid = 1'b1;
          sData  = 8'hE0;
          stage  = 2;
        end else if (acc) begin
          accepted++;
          if (stage == 0 && accepted == 10) begin
            sValid = 1'b0;
            stage  = 1;
          end else if (stage == 0) begin
            sData = 8'h10 + 8'(accepted);
          end else if (stage == 2 && accepted == 13) begin
            sValid = 1'b0;
            sLast  = 1'b0;
            stage  = 3;
          end else if (stage == 2) begin
            sData = 8'hE0 + 8'(accepted - 10);
            sLast = (accepted == 12);
          end
        end
      end
    end
    wrong = 0;
    for (int i = 0; i < gotData.size() && i < expU.size(); i++)
      if (gotData[i] !== expU[i]) wrong++;
    checkOutput("underrun sequence finished", stage, 4);
    checkOutput("underrun error pulses", pulses, 1);
    checkOutput("underrun control 01 cycles", errCycles, 1);
    checkOutput("underrun error-cycle data", errData, 0);
    checkOutput("underrun data bytes sent", gotData.size(), expU.size());
    checkOutput("underrun wrong bytes", wrong, 0);
    checkOutput("underrun busy cycles after drain", busyAfter, IFG);
    checkOutput("underrun idle {ctrl,ready}", {txCtrl, sReady}, 3'b000);
  endtask

  task automatic runResetMidFrame();
    int idx, cyc;
    bit acc;
    resetDut();
    clearFrames();
    addFrame(40, 8'h60, 0, MINLEN);
    idx = 0;
    cyc = 0;
    @(posedge clock);
    #1;
    sValid = 1'b1;
    sData  = txBytes[0];
    sLast  = 1'b0;
    while (idx < 5 && cyc < 200) begin
      @(negedge clock);
      acc = sValid && sReady;
      @(posedge clock);
      #1;
      if (acc) begin
        idx++;
        sData = txBytes[idx];
      end
      cyc++;
    end
    checkOutput("reset test reached payload", idx, 5);
    @(negedge clock);
    checkOutput("reset test {busy,ctrl} before reset", {busy, txCtrl}, 3'b111);
    #1;
    resetN = 1'b0;
    #1;
    checkOutput("async reset outputs", {txData, txCtrl, sReady, busy, underrunError}, 13'd0);
    sValid = 1'b0;
    sLast  = 1'b0;
    @(negedge clock);
    resetN = 1'b1;
    repeat (2) @(negedge clock);
    clearFrames();
    addFrame(30, 8'h00, 1, MINLEN);
    applyStimulus(1, 0);
    checkFrames("after reset", 1, 0);
  endtask

  initial begin
    resetN = 1'b0;
    sValid = 1'b0;
    sLast  = 1'b0;
    sData  = 8'h00;
    #2;
    checkOutput("reset state", {txData, txCtrl, sReady, busy, underrunError}, 13'd0);
    checkOutput("reset state no-pad", {npData, npCtrl, npReady, npBusy, npUnderrun}, 13'd0);
    @(negedge clock);
    resetN = 1'b1;
    repeat (2) @(negedge clock);

    vecs[0] = '{"crc 123456789", 9, 8'h31, 1'b1, 21, 1'b1, 32'hCBF43926};
    vecs[1] = '{"single byte AB", 1, 8'hAB, 1'b0, 72, 1'b0, 32'h0};
    vecs[2] = '{"59 bytes",      59, 8'h10, 1'b0, 72, 1'b0, 32'h0};
    vecs[3] = '{"60 bytes",      60, 8'h20, 1'b0, 72, 1'b0, 32'h0};
    vecs[4] = '{"61 bytes",      61, 8'h30, 1'b0, 73, 1'b0, 32'h0};
    vecs[5] = '{"64 bytes",      64, 8'h40, 1'b0, 76, 1'b0, 32'h0};

    for (int i = 0; i < 6; i++) begin
      resetDut();
      clearFrames();
      addFrame(vecs[i].len, vecs[i].startVal, 0, vecs[i].noPad ? 0 : MINLEN);
      applyStimulus(1, vecs[i].noPad);
      checkFrames(vecs[i].name, 1, 0);
      checkOutput({vecs[i].name, " wire length"}, lastRunLen, vecs[i].expLen);
      if (vecs[i].fcsKnown) checkOutput({vecs[i].name, " fcs"}, lastFcs, vecs[i].expFcs);
    end

    runUnderrun();

    resetDut();
    clearFrames();
    addFrame(64, 8'h00, 1, MINLEN);
    addFrame(64, 8'h00, 1, MINLEN);
    applyStimulus(2, 0);
    checkFrames("back-to-back", 2, 1);

    runResetMidFrame();

    repeat (IFG + 4) @(negedge clock);
    for (int r = 0; r < 5; r++) begin
      int len;
      len = (r == 0) ? $urandom_range(1, 70) : $urandom_range(1, 1500);
      clearFrames();
      addFrame(len, 8'h00, 1, MINLEN);
      applyStimulus(1, 0);
      checkFrames($sformatf("random len %0d", len), 1, 0);
      repeat (IFG + 4) @(negedge clock);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
